// File: rtl/ifetch.sv
// Instruction fetch unit: program counter, instruction register and a one-entry
// prefetch buffer filled from instruction memory over a req/ack handshake.
module ifetch #(
  parameter int unsigned PC_W = 16
) (
  input  logic            clk,
  input  logic            rst_f,
  input  logic            ir_load,
  input  logic            pc_write,
  input  logic            pc_sel,
  input  logic            br_sel,
  input  logic            pc_rst,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  output logic [PC_W-1:0] pc_out,
  output logic [31:0]     ir,
  output logic [3:0]      opcode,
  output logic [3:0]      mm,
  output logic            stall
);

  typedef enum logic [1:0] {StIdle, StFetch, StGap, StValid} state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] fetch_addr_q, fetch_addr_d;
  logic [PC_W-1:0] buf_addr_q, buf_addr_d;
  logic [31:0]     ir_q, ir_d;
  logic [31:0]     buf_q, buf_d;
  logic            buf_valid_q, buf_valid_d;

  logic [PC_W-1:0] br_offset, br_addr, pc_in;
  logic            hit_buf, hit_bypass, hit;

  // Branch offset is zero-extended; all PC arithmetic wraps at 2^PC_W.
  assign br_offset = PC_W'(ir_q[15:0]);
  assign br_addr   = br_sel ? br_offset : pc_q + br_offset;
  assign pc_in     = pc_sel ? br_addr : pc_q + PC_W'(1);

  assign hit_buf    = (state_q == StValid) && buf_valid_q && (buf_addr_q == pc_q);
  assign hit_bypass = (state_q == StFetch) && imem_ack && (fetch_addr_q == pc_q);
  assign hit        = hit_buf | hit_bypass;
  assign stall      = ir_load & ~hit;

  always_comb begin
    pc_d = pc_q;
    if (pc_rst) begin
      pc_d = '0;
    end else if (pc_write && !stall) begin
      pc_d = pc_in;
    end
  end

  always_comb begin
    ir_d = ir_q;
    if (ir_load && hit) begin
      ir_d = hit_buf ? buf_q : imem_rdata;
    end
  end

  // PC changes never cancel an outstanding request; a stale word is dropped at ack.
  always_comb begin
    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;
    buf_d        = buf_q;
    buf_addr_d   = buf_addr_q;
    buf_valid_d  = buf_valid_q;
    imem_req     = 1'b0;
    unique case (state_q)
      StIdle: begin
        state_d      = StFetch;
        fetch_addr_d = pc_d;
      end
      StFetch: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          if (fetch_addr_q == pc_q) begin
            buf_d       = imem_rdata;
            buf_addr_d  = fetch_addr_q;
            buf_valid_d = 1'b1;
            state_d     = StValid;
          end else begin
            state_d = StGap;
          end
        end
      end
      StGap: begin
        state_d      = StFetch;
        fetch_addr_d = pc_d;
      end
      StValid: begin
        if (buf_addr_q != pc_d) begin
          buf_valid_d  = 1'b0;
          state_d      = StFetch;
          fetch_addr_d = pc_d;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_f) begin
      state_q      <= StIdle;
      pc_q         <= '0;
      ir_q         <= '0;
      buf_q        <= '0;
      buf_addr_q   <= '0;
      buf_valid_q  <= 1'b0;
      fetch_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      buf_q        <= buf_d;
      buf_addr_q   <= buf_addr_d;
      buf_valid_q  <= buf_valid_d;
      fetch_addr_q <= fetch_addr_d;
    end
  end

  assign imem_addr = fetch_addr_q;
  assign pc_out    = pc_q;
  assign ir        = ir_q;
  assign opcode    = ir_q[31:28];
  assign mm        = ir_q[27:24];

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch: programmable-latency memory responder, a per-cycle
// transaction-level reference model, and hand-computed checkpoints.
module tb_ifetch;

  logic        clk = 1'b0;
  logic        rst_f = 1'b0;
  logic        ir_load = 1'b0, pc_write = 1'b0, pc_sel = 1'b0, br_sel = 1'b0, pc_rst = 1'b0;
  logic        ack_auto = 1'b0, force_ack = 1'b0;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        imem_req;
  logic [15:0] imem_addr, pc_out;
  logic [31:0] ir;
  logic [3:0]  opcode, mm;
  logic        stall;

  int checks = 0;
  int failures = 0;
  int lat = 1;
  int wcnt = 0;

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    case (a)
      16'h0000: return 32'h1000_0005;
      16'h0001: return 32'h2100_0002;
      16'h0002: return 32'h3200_0040;
      16'h0003: return 32'h4300_0003;
      16'h0040: return 32'h5400_FFFE;
      16'hFFFE: return 32'h6500_0003;
      16'hFFFF: return 32'h7600_0001;
      default:  return {16'hAB00, a};
    endcase
  endfunction

  assign imem_ack   = force_ack | ack_auto;
  assign imem_rdata = force_ack ? 32'hDEAD_BEEF : mem_word(imem_addr);

  ifetch #(.PC_W(16)) dut (
    .clk        (clk),
    .rst_f      (rst_f),
    .ir_load    (ir_load),
    .pc_write   (pc_write),
    .pc_sel     (pc_sel),
    .br_sel     (br_sel),
    .pc_rst     (pc_rst),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .pc_out     (pc_out),
    .ir         (ir),
    .opcode     (opcode),
    .mm         (mm),
    .stall      (stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Memory: ack arrives lat cycles after req rises.
  initial forever begin
    @(negedge clk);
    if (imem_req !== 1'b1 || imem_ack === 1'b1) wcnt = 0;
    else wcnt++;
  end
  initial forever begin
    @(posedge clk);
    #1;
    ack_auto = (imem_req === 1'b1) && (wcnt >= lat);
  end

  // Reference model: PC/IR, one outstanding request, one quiet cycle, one buffered word.
  logic [15:0] m_pc = '0, m_addr = '0, m_ba = '0;
  logic [31:0] m_ir = '0, m_bd = '0;
  bit          m_busy = 0, m_quiet = 0, m_bv = 0, m_ok = 0;

  initial begin
    logic [15:0] n_pc, n_addr, n_ba, p_in;
    logic [31:0] n_ir, n_bd;
    bit          n_busy, n_quiet, n_bv, h_buf, h_mem, e_stall;
    forever begin
      @(negedge clk);
      h_buf   = !m_busy && !m_quiet && m_bv && (m_ba == m_pc);
      h_mem   = m_busy && (imem_ack === 1'b1) && (m_addr == m_pc);
      e_stall = ir_load && !(h_buf || h_mem);
      p_in    = !pc_sel ? m_pc + 16'd1 : (br_sel ? m_ir[15:0] : m_pc + m_ir[15:0]);
      if (m_ok) begin
        chk("req", 32'(imem_req), 32'(m_busy));
        if (m_busy) chk("addr", 32'(imem_addr), 32'(m_addr));
        chk("pc", 32'(pc_out), 32'(m_pc));
        chk("ir", ir, m_ir);
        chk("opcode", 32'(opcode), 32'(m_ir[31:28]));
        chk("mm", 32'(mm), 32'(m_ir[27:24]));
        chk("stall", 32'(stall), 32'(e_stall));
      end
      n_addr = m_addr; n_ba = m_ba; n_bd = m_bd;
      n_busy = m_busy; n_quiet = m_quiet; n_bv = m_bv;
      if (!rst_f) begin
        n_pc = '0; n_ir = '0; n_bv = 0; n_busy = 0; n_quiet = 1;
      end else begin
        n_pc = pc_rst ? 16'd0 : ((pc_write && !e_stall) ? p_in : m_pc);
        n_ir = (ir_load && !e_stall) ? (h_buf ? m_bd : mem_word(m_addr)) : m_ir;
        if (m_quiet) begin
          n_quiet = 0; n_busy = 1; n_addr = n_pc;
        end else if (m_busy) begin
          if (imem_ack === 1'b1) begin
            n_busy = 0;
            if (m_addr == m_pc) begin
              n_bv = 1; n_ba = m_addr; n_bd = mem_word(m_addr);
            end else begin
              n_quiet = 1;
            end
          end
        end else if (m_ba != n_pc) begin
          n_bv = 0; n_busy = 1; n_addr = n_pc;
        end
      end
      @(posedge clk);
      m_pc = n_pc; m_ir = n_ir; m_addr = n_addr; m_ba = n_ba; m_bd = n_bd;
      m_busy = n_busy; m_quiet = n_quiet; m_bv = n_bv;
      if (!rst_f) m_ok = 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hold ir_load (with PC command) until the load completes.
  task automatic fetch_step(input logic pcw, input logic sel, input logic brs);
    bit done = 0;
    ir_load = 1'b1; pc_write = pcw; pc_sel = sel; br_sel = brs;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      done = (stall === 1'b0);
      step();
    end
    chk("load_done", 32'(done), 32'd1);
    ir_load = 1'b0; pc_write = 1'b0; pc_sel = 1'b0; br_sel = 1'b0;
  endtask

  task automatic pc_cmd(input logic sel, input logic brs);
    pc_write = 1'b1; pc_sel = sel; br_sel = brs;
    step();
    pc_write = 1'b0; pc_sel = 1'b0; br_sel = 1'b0;
  endtask

  task automatic wait_req(input logic [15:0] a);
    bit found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      found = (imem_req === 1'b1) && (imem_addr == a);
    end
    chk("wait_req", 32'(found), 32'd1);
  endtask

  initial begin
    int  nst;
    bit  done;

    // Reset state and first fetch with 1-cycle memory.
    step(); step();
    ir_load = 1'b1;
    @(negedge clk);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_pc", 32'(pc_out), 32'd0);
    chk("rst_ir", ir, 32'd0);
    chk("rst_stall", 32'(stall), 32'd1);
    step();
    rst_f = 1'b1; ir_load = 1'b0;
    step();
    @(negedge clk);
    chk("first_req", 32'(imem_req), 32'd1);
    chk("first_addr", 32'(imem_addr), 32'd0);
    step();
    ir_load = 1'b1; pc_write = 1'b1;
    @(negedge clk);
    chk("bypass_stall", 32'(stall), 32'd0);
    step();
    ir_load = 1'b0; pc_write = 1'b0;
    @(negedge clk);
    chk("first_ir", ir, 32'h1000_0005);
    chk("first_opcode", 32'(opcode), 32'd1);
    chk("first_mm", 32'(mm), 32'd0);
    chk("first_pc", 32'(pc_out), 32'd1);

    // Wait states: ack 4 cycles after req.
    step();
    lat = 4; rst_f = 1'b0;
    step();
    rst_f = 1'b1;
    step(); step();
    ir_load = 1'b1; pc_write = 1'b1;
    nst = 0; done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (stall === 1'b1) begin
        nst++;
        chk("ws_pc_hold", 32'(pc_out), 32'd0);
      end else begin
        done = 1;
      end
      step();
    end
    ir_load = 1'b0; pc_write = 1'b0;
    chk("ws_stall_cycles", 32'(nst), 32'd3);
    @(negedge clk);
    chk("ws_pc", 32'(pc_out), 32'd1);
    chk("ws_ir", ir, 32'h1000_0005);

    // Sequential flow, then redirect while fetch of 3 is in flight.
    step();
    lat = 1;
    fetch_step(1'b1, 1'b0, 1'b0);
    fetch_step(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("seq_ir", ir, 32'h3200_0040);
    chk("seq_pc", 32'(pc_out), 32'd3);
    lat = 3;
    wait_req(16'd3);
    step();
    pc_cmd(1'b1, 1'b1);
    @(negedge clk);
    chk("redir_pc", 32'(pc_out), 32'h0040);
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      done = (imem_ack === 1'b1);
    end
    chk("redir_ack_seen", 32'(done), 32'd1);
    @(negedge clk);
    chk("gap_req", 32'(imem_req), 32'd0);
    @(negedge clk);
    chk("refetch_req", 32'(imem_req), 32'd1);
    chk("refetch_addr", 32'(imem_addr), 32'h0040);

    // Absolute branch, PC+1 wrap, relative-branch wrap.
    step();
    fetch_step(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("br_ir", ir, 32'h5400_FFFE);
    chk("br_pc", 32'(pc_out), 32'h0041);
    step();
    pc_cmd(1'b1, 1'b1);
    @(negedge clk);
    chk("abs_pc", 32'(pc_out), 32'hFFFE);
    step();
    pc_cmd(1'b0, 1'b0);
    pc_cmd(1'b0, 1'b0);
    @(negedge clk);
    chk("inc_wrap_pc", 32'(pc_out), 32'h0000);
    step();
    pc_cmd(1'b1, 1'b1);
    fetch_step(1'b0, 1'b0, 1'b0);
    pc_cmd(1'b1, 1'b0);

    // pc_rst while a load is stalled on an empty buffer.
    ir_load = 1'b1; pc_rst = 1'b1;
    @(negedge clk);
    chk("rel_wrap_pc", 32'(pc_out), 32'h0001);
    chk("pcrst_stall", 32'(stall), 32'd1);
    step();
    ir_load = 1'b0; pc_rst = 1'b0;
    @(negedge clk);
    chk("pcrst_pc", 32'(pc_out), 32'd0);
    chk("pcrst_ir", ir, 32'h6500_0003);

    // Reset mid-request; the late ack must be ignored.
    step();
    lat = 6;
    wait_req(16'd0);
    step();
    rst_f = 1'b0;
    @(negedge clk);
    chk("midrst_req", 32'(imem_req), 32'd1);
    step();
    rst_f = 1'b1; force_ack = 1'b1;
    @(negedge clk);
    chk("late_ack_req", 32'(imem_req), 32'd0);
    chk("late_ack_ir", ir, 32'd0);
    chk("late_ack_pc", 32'(pc_out), 32'd0);
    step();
    force_ack = 1'b0;
    @(negedge clk);
    chk("post_rst_req", 32'(imem_req), 32'd1);
    chk("post_rst_addr", 32'(imem_addr), 32'd0);
    step();
    lat = 1;
    fetch_step(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("final_ir", ir, 32'h1000_0005);
    chk("final_pc", 32'(pc_out), 32'd1);
    repeat (4) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ifetch.md
# ifetch

Instruction fetch unit for the SISC datapath. Owns the program counter and instruction register, fetches 32-bit instructions from instruction memory over a req/ack handshake into a one-entry prefetch buffer, and presents `opcode`/`mm` to the control FSM. It executes the FSM's PC and IR commands (`pc_rst`, `pc_write`, `pc_sel`, `br_sel`, `ir_load`) and raises `stall` when an IR load cannot complete.

## Interface
- `PC_W`, 16, PC and instruction-memory address width.
- `clk`  in  1  system clock; all state updates on posedge.
- `rst_f`  in  1  reset; one clock, reset synchronous and active-low.
- `ir_load`  in  1  load IR from the instruction at the current PC.
- `pc_write`  in  1  PC <= pc_in.
- `pc_sel`  in  1  0: pc_in = PC+1; 1: pc_in = br_addr.
- `br_sel`  in  1  1: br_addr = IR[15:0] (absolute); 0: br_addr = PC + IR[15:0] (relative).
- `pc_rst`  in  1  synchronous PC <= 0.
- `imem_ack`  in  1  memory data valid this cycle.
- `imem_rdata`  in  32  instruction word, valid when `imem_ack`=1.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  PC_W  fetch address.
- `pc_out`  out  PC_W  current PC.
- `ir`  out  32  instruction register.
- `opcode`  out  4  IR[31:28].
- `mm`  out  4  IR[27:24].
- `stall`  out  1  combinational; IR load requested but not satisfiable this cycle.

## Operation
- States: IDLE, FETCH, GAP, VALID. Registers: PC, IR, buf (32), buf_addr, buf_valid, fetch_addr.
- pc_next = 0 if `pc_rst`; else pc_in if `pc_write` & ~`stall`; else PC. pc_rst has priority and is never blocked by stall.
- Arithmetic: PC+1 and PC+IR[15:0] modulo 2^PC_W (wrap 0xFFFF -> 0x0000); IR[15:0] not sign-extended.
- hit = (state==VALID & buf_valid & buf_addr==PC) | (state==FETCH & `imem_ack` & fetch_addr==PC).
- `stall` = `ir_load` & ~hit. On `ir_load` & hit: IR <= buf, or IR <= `imem_rdata` on the bypass path. While stall=1, IR and PC hold (except pc_rst); the control FSM holds its state while `stall`=1.
- IDLE -> FETCH unconditionally; fetch_addr <= pc_next.
- FETCH: `imem_req`=1, `imem_addr`=fetch_addr, both stable until ack. On ack with fetch_addr==PC: buf <= rdata, buf_addr <= fetch_addr, buf_valid <= 1, -> VALID. On ack with fetch_addr!=PC (redirect during flight): data discarded, -> GAP.
- GAP: `imem_req`=0 for exactly one cycle, -> FETCH with fetch_addr <= pc_next.
- VALID: `imem_req`=0. buf_addr==pc_next: stay. Otherwise buf_valid <= 0, -> FETCH with fetch_addr <= pc_next.
- PC changes (pc_write, pc_rst) never abort an in-flight request; the mismatch is resolved at ack.
- Reset (rst_f=0 at posedge, any state, including mid-request): PC=0, IR=0, buf_valid=0, fetch_addr=0, state=IDLE. Outputs during/after reset: imem_req=0, imem_addr=0, pc_out=0, ir=0, opcode=0, mm=0; stall follows its equation (=ir_load). A late ack arriving in IDLE/GAP/VALID is ignored.

## Timing
- Handshake: req rises on FETCH entry; memory asserts ack ≥1 cycle after req rises; req falls the cycle after ack. No back-to-back req without an intervening low cycle.
- Reset release at edge t0: t0+1 FETCH (req=1, addr=0). With 1-cycle memory (ack in cycle after req), the instruction is available in cycle t0+2 (bypass) and in buf from t0+3.
- Sequential flow (ir_load+pc_write in same cycle on a hit): IR updated, PC+1 at the same edge; next cycle VALID detects mismatch -> FETCH of PC+1 issued one cycle later.
- Branch taken (pc_sel=1, pc_write=1) during FETCH: in-flight word discarded on ack; GAP 1 cycle; refetch at branch target.
- stall is combinational from ir_load, state, imem_ack and address compare; no registered latency.

## Test plan
- Reset then run: memory holds 0x10000005 at addr 0, ack 1 cycle after req -> req at t0+1 addr 0; ir_load at t0+2 gives stall=0, ir=0x10000005, opcode=1, mm=0, pc_out=1.
- Wait states: ack 4 cycles after req, ir_load held -> stall=1 for 3 cycles, PC holds 0 despite pc_write; IR loads on ack cycle, PC->1.
- Redirect in flight: FETCH addr 3 pending, branch pc_sel=1, br_sel=1, IR[15:0]=0x0040 -> PC=0x0040; ack for 3 discarded, GAP one cycle, next req addr 0x0040.
- Relative wrap: PC=0xFFFE, IR[15:0]=0x0003, br_sel=0, pc_sel=1, pc_write=1 -> PC=0x0001; PC=0xFFFF with pc_sel=0 -> PC=0x0000.
- Reset mid-request: rst_f=0 while req=1 awaiting ack; ack arrives next cycle -> ignored, ir=0, req low for one cycle, then req addr 0.
- pc_rst vs stall: ir_load with buffer empty (stall=1) and pc_rst=1 -> PC=0 next edge, IR unchanged.
